// File: rtl/encoder_proj_tx.sv
// Hamming(7,4) encoder feeding a UART-style serial transmitter (start, LSB-first data, stop).
// Define ENCODER_PROJ_SECDED_EN to append overall parity p0 as an 8th serial data bit.
module encoder_proj_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_i,
  input  logic [3:0] in_data_i,
  output logic       in_ready_o,
  output logic [6:0] cw_o,
  output logic       cw_valid_o,
  output logic       tx_o,
  output logic       busy_o
);

`ifdef ENCODER_PROJ_SECDED_EN
  localparam int NBITS = 8;
`else
  localparam int NBITS = 7;
`endif
  localparam logic [7:0] DIV_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST = 3'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] frame_q, frame_d;
  logic [6:0] cw_q, cw_d;
  logic       cw_valid_q, cw_valid_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic [6:0] enc;

  function automatic logic [6:0] hamming_enc(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  assign enc        = hamming_enc(in_data_i);
  assign in_ready_o = (state_q == IDLE);
  assign cw_o       = cw_q;
  assign cw_valid_o = cw_valid_q;
  assign tx_o       = tx_q;
  assign busy_o     = busy_q;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    frame_d    = frame_q;
    cw_d       = cw_q;
    cw_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d    = START;
          div_d      = '0;
          bit_d      = '0;
          cw_d       = enc;
          cw_valid_d = 1'b1;
`ifdef ENCODER_PROJ_SECDED_EN
          frame_d    = {^enc, enc};
`else
          frame_d    = {1'b0, enc};
`endif
        end
      end
      START: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = DATA;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      DATA: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
    endcase

    // Line level is derived from the next state so tx_o is a clean flop output.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = frame_d[bit_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      frame_q    <= '0;
      cw_q       <= '0;
      cw_valid_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      cw_q       <= cw_d;
      cw_valid_q <= cw_valid_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_encoder_proj_tx.sv
// Bench for encoder_proj_tx: random nibbles checked against a positional Hamming model and frame timing.
module tb_encoder_proj_tx;
  localparam int CPB = 4;
`ifdef ENCODER_PROJ_SECDED_EN
  localparam int NB = 8;
`else
  localparam int NB = 7;
`endif
  localparam int FRAME_LEN = (2 + NB) * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_ready_o;
  logic [6:0] cw_o;
  logic       cw_valid_o;
  logic       tx_o;
  logic       busy_o;
  int         total = 0;
  int         bad = 0;

  encoder_proj_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready_o), .cw_o(cw_o), .cw_valid_o(cw_valid_o),
    .tx_o(tx_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Classic Hamming positions 1..7: parity at powers of two, cw[k] = position k+1.
  function automatic logic [6:0] ref_cw(input logic [3:0] d);
    logic [7:1] pos;
    pos    = '0;
    pos[3] = d[0];
    pos[5] = d[1];
    pos[6] = d[2];
    pos[7] = d[3];
    for (int p = 1; p <= 4; p = p * 2) begin
      logic par;
      par = 1'b0;
      for (int q = 1; q <= 7; q++)
        if (q != p && (q & p) != 0) par = par ^ pos[q];
      pos[p] = par;
    end
    return pos;
  endfunction

  function automatic logic ref_tx(input logic [6:0] cw, input int i);
    int b;
    b = i / CPB;
    if (b == 0) return 1'b0;
    if (b <= NB) begin
      if (b - 1 < 7) return cw[b-1];
      return ^cw;
    end
    return 1'b1;
  endfunction

  task automatic send_frame(input logic [3:0] nib, input logic keep, input logic [3:0] nxt);
    logic [6:0] ecw;
    ecw = ref_cw(nib);
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL ready_pre got=%b exp=1", in_ready_o); end
    in_valid = 1'b1;
    in_data  = nib;
    step();
    in_valid = keep;
    total++; if (cw_valid_o !== 1'b1) begin bad++; $display("FAIL cw_valid_pulse got=%b exp=1", cw_valid_o); end
    for (int i = 0; i < FRAME_LEN; i++) begin
      total++; if (tx_o !== ref_tx(ecw, i)) begin bad++; $display("FAIL tx nib=%h i=%0d got=%b exp=%b", nib, i, tx_o, ref_tx(ecw, i)); end
      total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL busy i=%0d got=%b exp=1", i, busy_o); end
      total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL ready_busy i=%0d got=%b exp=0", i, in_ready_o); end
      total++; if (cw_o !== ecw) begin bad++; $display("FAIL cw nib=%h got=%b exp=%b", nib, cw_o, ecw); end
      if (i > 0) begin
        total++; if (cw_valid_o !== 1'b0) begin bad++; $display("FAIL cw_valid_width i=%0d got=%b exp=0", i, cw_valid_o); end
      end
      in_data = (keep && i == FRAME_LEN - 1) ? nxt : 4'($urandom);
      step();
    end
    total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL idle_tx got=%b exp=1", tx_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy_o); end
    total++; if (cw_valid_o !== 1'b0) begin bad++; $display("FAIL idle_cw_valid got=%b exp=0", cw_valid_o); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b exp=1", tx_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    total++; if (cw_o !== 7'd0) begin bad++; $display("FAIL rst_cw got=%b exp=0", cw_o); end
    total++; if (cw_valid_o !== 1'b0) begin bad++; $display("FAIL rst_cw_valid got=%b exp=0", cw_valid_o); end
    rst_n = 1'b1;
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", in_ready_o); end
    for (int i = 0; i < 20; i++) begin
      step();
      total++; if (tx_o !== 1'b1 || in_ready_o !== 1'b1 || busy_o !== 1'b0 || cw_valid_o !== 1'b0) begin
        bad++; $display("FAIL idle20 i=%0d got tx=%b rdy=%b busy=%b cwv=%b exp 1 1 0 0", i, tx_o, in_ready_o, busy_o, cw_valid_o);
      end
    end
  endtask

  task automatic test_known();
    send_frame(4'b1011, 1'b0, 4'h0);
    total++; if (cw_o !== 7'b1010101) begin bad++; $display("FAIL known_1011 got=%b exp=1010101", cw_o); end
    send_frame(4'b0000, 1'b0, 4'h0);
    total++; if (cw_o !== 7'b0000000) begin bad++; $display("FAIL known_0000 got=%b exp=0000000", cw_o); end
    send_frame(4'b1111, 1'b0, 4'h0);
    total++; if (cw_o !== 7'b1111111) begin bad++; $display("FAIL known_1111 got=%b exp=1111111", cw_o); end
    send_frame(4'b0001, 1'b0, 4'h0);
    total++; if (cw_o !== 7'b0000111) begin bad++; $display("FAIL known_0001 got=%b exp=0000111", cw_o); end
  endtask

  task automatic test_all_nibbles();
    for (int n = 0; n < 16; n++) begin
      send_frame(4'(n), 1'b0, 4'h0);
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] a, b, c;
    a = 4'($urandom);
    b = 4'($urandom);
    c = 4'($urandom);
    send_frame(a, 1'b1, b);
    send_frame(b, 1'b1, c);
    send_frame(c, 1'b0, 4'h0);
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] nib;
    logic [6:0] ecw;
    nib = 4'($urandom);
    ecw = ref_cw(nib);
    in_valid = 1'b1;
    in_data  = nib;
    step();
    in_valid = 1'b0;
    repeat (4 * CPB + 1) step();
    total++; if (tx_o !== ecw[3]) begin bad++; $display("FAIL mid_bit3 got=%b exp=%b", tx_o, ecw[3]); end
    rst_n = 1'b0;
    step();
    total++; if (tx_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL abort got tx=%b busy=%b exp 1 0", tx_o, busy_o); end
    total++; if (cw_o !== 7'd0 || cw_valid_o !== 1'b0) begin bad++; $display("FAIL abort_cw got=%b/%b exp 0/0", cw_o, cw_valid_o); end
    rst_n = 1'b1;
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", in_ready_o); end
    for (int i = 0; i < FRAME_LEN + 4; i++) begin
      step();
      total++; if (tx_o !== 1'b1 || busy_o !== 1'b0 || in_ready_o !== 1'b1) begin
        bad++; $display("FAIL no_resume i=%0d got tx=%b busy=%b rdy=%b exp 1 0 1", i, tx_o, busy_o, in_ready_o);
      end
    end
    send_frame(4'($urandom), 1'b0, 4'h0);
  endtask

  initial begin
    test_reset();
    test_known();
    test_all_nibbles();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder_proj_tx.md
ENCODER_PROJ_TX -- requirements
Module: encoder_proj_tx

Interface
REQ-001: Parameter CLKS_PER_BIT, default 4, clocks per serial bit; legal range 1..255.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst_n  input  1  reset, synchronous, active-low.
REQ-004: in_valid_i  input  1  4-bit nibble on in_data_i is offered.
REQ-005: in_data_i  input  4  data nibble; d1=bit0, d2=bit1, d3=bit2, d4=bit3.
REQ-006: in_ready_o  output  1  block can accept a nibble this cycle.
REQ-007: cw_o  output  7  registered Hamming(7,4) codeword of the last accepted nibble.
REQ-008: cw_valid_o  output  1  one-cycle pulse when cw_o updates.
REQ-009: tx_o  output  1  serial line; idle high.
REQ-010: busy_o  output  1  high while a frame is in flight.

Function
REQ-011: Transfer SHALL occur on a rising edge where in_valid_i and in_ready_o are both high.
REQ-012: in_ready_o SHALL be high only in state IDLE; it is combinationally equal to (state==IDLE).
REQ-013: Parity SHALL be p1=d1^d2^d4, p2=d1^d3^d4, p3=d2^d3^d4.
REQ-014: Codeword bit order SHALL be cw_o[6:0]={d4,d3,d2,p3,d1,p2,p1}.
REQ-015: On transfer cycle N, cw_o and cw_valid_o=1 SHALL appear at cycle N+1; cw_o holds until next transfer.
REQ-016: FSM states SHALL be IDLE, START, DATA, STOP.
REQ-017: IDLE->START on transfer; START->DATA after CLKS_PER_BIT clocks; DATA->STOP after last data bit held CLKS_PER_BIT clocks; STOP->IDLE after CLKS_PER_BIT clocks.
REQ-018: tx_o SHALL be 1 in IDLE, 0 in START, the current codeword bit in DATA, 1 in STOP.
REQ-019: Data bits SHALL be sent LSB first (cw[0]=p1 first).
REQ-020: First start-bit clock of tx_o=0 SHALL be cycle N+1; frame length = (2+data bits)*CLKS_PER_BIT clocks.
REQ-021: busy_o SHALL be high in START, DATA, STOP; low in IDLE.
REQ-022: in_valid_i while not in IDLE SHALL be ignored; in_data_i changes mid-frame SHALL not affect the frame in flight.
REQ-023: Back-to-back: nibble held valid SHALL be accepted on the first cycle back in IDLE, giving exactly one idle-high clock between frames.
REQ-024: Bit counter and divider counter SHALL wrap to zero at each bit/frame boundary, no extra cycles.

Reset
REQ-025: While rst_n=0 at a rising edge: state=IDLE, tx_o=1, cw_o=0, cw_valid_o=0, busy_o=0, counters=0.
REQ-026: Reset asserted mid-frame SHALL abort the frame; tx_o=1 from the next edge; the aborted nibble is not retransmitted.
REQ-027: in_ready_o SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-028: Macro ENCODER_PROJ_SECDED_EN, when defined, SHALL append overall parity p0=XOR of cw[6:0] as an 8th serial data bit after cw[6]; cw_o stays 7 bits.
REQ-029: Without ENCODER_PROJ_SECDED_EN, DATA SHALL carry exactly 7 bits; frame = 9*CLKS_PER_BIT clocks (10* with macro).

Verification
REQ-030: Reset, then idle 20 cycles -> tx_o=1, in_ready_o=1, busy_o=0, cw_valid_o never asserted.
REQ-031: in_data_i=4'b1011 accepted, CLKS_PER_BIT=4 -> cw_o=7'b1010101, cw_valid_o pulse 1 cycle; tx_o sequence per 4 clocks: 0,1,0,1,0,1,0,1,1; busy_o high 36 cycles.
REQ-032: Data 4'b0000, 4'b1111, 4'b0001 -> cw_o 7'b0000000, 7'b1111111, 7'b0000111; all 16 nibbles checked against REQ-013/014 model.
REQ-033: in_valid_i held high with two nibbles back-to-back -> second start bit begins exactly 1 clock after first stop bit ends; in_data_i toggled mid-frame has no effect.
REQ-034: rst_n pulsed low during DATA bit 3 -> tx_o=1, busy_o=0 next cycle, in_ready_o=1 after release, no partial-frame resumption.
REQ-035: With ENCODER_PROJ_SECDED_EN, data 4'b1011 -> serial data bits 1,0,1,0,1,0,1 then p0=0, then stop; frame 40 cycles at CLKS_PER_BIT=4.
